e3_bcd_dec: RTL and testbench

- Sequential Excess-3 to BCD decoder; the receive-side counterpart of the team's BCD to Excess-3 encoder.
- Accepts one Excess-3 digit per handshake, most significant digit first. A number is terminated by in_last.
- Subtracts 3 from each digit, checks that the code is legal and packs the digits into a right-aligned multi-digit BCD word.
- Presents the finished word with error flags on an output valid/ready handshake.
- Sits between a serial Excess-3 source (keypad or link) and the BCD arithmetic/display datapath.

---
 rtl/e3_pkg.sv | 13 +
 rtl/e3_digit_dec.sv | 17 +
 rtl/e3_bcd_dec.sv | 110 +++++++++++
 tb/tb_e3_bcd_dec.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/e3_pkg.sv
// Shared Excess-3 constants and the decoder FSM state encoding.
package e3_pkg;

    localparam logic [3:0] E3_OFFSET = 4'd3;
    localparam logic [3:0] E3_MIN    = 4'd3;
    localparam logic [3:0] E3_MAX    = 4'd12;

    typedef logic [0:0] e3_state_t;

    localparam e3_state_t COLLECT = 1'b0;
    localparam e3_state_t HOLD    = 1'b1;

endpackage

// File: rtl/e3_digit_dec.sv
// Single Excess-3 digit to BCD nibble; illegal codes decode to zero with o_legal_c low.
module e3_digit_dec
    import e3_pkg::*;
(
    input  logic [3:0] i_e3,
    output logic [3:0] o_bcd_c,
    output logic       o_legal_c
);

    logic w_legal;

    assign w_legal   = (i_e3 >= E3_MIN) && (i_e3 <= E3_MAX);
    // Subtract only on legal codes so no wrapped value leaks out.
    assign o_bcd_c   = w_legal ? 4'(i_e3 - E3_OFFSET) : 4'd0;
    assign o_legal_c = w_legal;

endmodule

// File: rtl/e3_bcd_dec.sv
// Serial Excess-3 to packed BCD decoder: collects digits MSD first until in_last,
// then holds the right-aligned word with error flags until the consumer takes it.
module e3_bcd_dec
    import e3_pkg::*;
#(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned CW      = $clog2(NDIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_e3,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NDIGITS-1:0] out_bcd,
    output logic [CW-1:0]        out_ndig,
    output logic                 out_err_code,
    output logic                 out_err_ovf
);

    localparam int unsigned AW = 4 * NDIGITS;

    e3_state_t     r_state;
    e3_state_t     w_state_nxt;
    logic [AW-1:0] r_acc;
    logic [AW-1:0] w_acc_nxt;
    logic [AW-1:0] w_acc_shl;
    logic [CW-1:0] r_ndig;
    logic [CW-1:0] w_ndig_nxt;
    logic          r_err_code;
    logic          w_err_code_nxt;
    logic          r_err_ovf;
    logic          w_err_ovf_nxt;
    logic [3:0]    w_nib;
    logic          w_legal;

    e3_digit_dec u_digit_dec (
        .i_e3      (in_e3),
        .o_bcd_c   (w_nib),
        .o_legal_c (w_legal)
    );

    // Shift the new nibble in at the bottom; the oldest digit falls off the top.
    if (NDIGITS > 1) begin : g_shift_multi
        assign w_acc_shl = {r_acc[AW-5:0], w_nib};
    end else begin : g_shift_single
        assign w_acc_shl = w_nib;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_ndig_nxt     = r_ndig;
        w_err_code_nxt = r_err_code;
        w_err_ovf_nxt  = r_err_ovf;
        case (r_state)
            COLLECT: begin
                if (in_valid) begin
                    w_acc_nxt = w_acc_shl;
                    if (!w_legal) begin
                        w_err_code_nxt = 1'b1;
                    end
                    if (r_ndig < CW'(NDIGITS)) begin
                        w_ndig_nxt = CW'(r_ndig + CW'(1));
                    end else begin
                        w_err_ovf_nxt = 1'b1;
                    end
                    if (in_last) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    w_state_nxt    = COLLECT;
                    w_acc_nxt      = '0;
                    w_ndig_nxt     = '0;
                    w_err_code_nxt = 1'b0;
                    w_err_ovf_nxt  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= COLLECT;
            r_acc      <= '0;
            r_ndig     <= '0;
            r_err_code <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_ndig     <= w_ndig_nxt;
            r_err_code <= w_err_code_nxt;
            r_err_ovf  <= w_err_ovf_nxt;
        end
    end

    assign in_ready     = (r_state == COLLECT);
    assign out_valid    = (r_state == HOLD);
    assign out_bcd      = r_acc;
    assign out_ndig     = r_ndig;
    assign out_err_code = r_err_code;
    assign out_err_ovf  = r_err_ovf;

endmodule

// File: tb/tb_e3_bcd_dec.sv
// Scoreboard bench for e3_bcd_dec: expected words queued at send time, compared on out_valid.
module tb_e3_bcd_dec;

    localparam int unsigned ND = 4;
    localparam int unsigned CW = 3;

    typedef struct packed {
        logic [4*ND-1:0] bcd;
        logic [CW-1:0]   ndig;
        logic            ec;
        logic            eo;
    } res_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_e3;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [4*ND-1:0] out_bcd;
    logic [CW-1:0]   out_ndig;
    logic            out_err_code;
    logic            out_err_ovf;

    res_t       sb[$];
    logic [3:0] stim[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    e3_bcd_dec #(.NDIGITS(ND), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_e3        (in_e3),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bcd      (out_bcd),
        .out_ndig     (out_ndig),
        .out_err_code (out_err_code),
        .out_err_ovf  (out_err_ovf)
    );

    always #5 clk = ~clk;

    // Drives stim back to back; returns at the negedge after the last transfer.
    task automatic send_stim(input bit term);
        foreach (stim[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_e3    = stim[i];
            in_last  = term && (i == stim.size() - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic res_t sample();
        return {out_bcd, out_ndig, out_err_code, out_err_ovf};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_e3 = 4'h0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        else n_pass++;
        n_checks++;
        if (sample() !== res_t'(0))
            $display("FAIL reset_data: got %h expected 0", sample());
        else n_pass++;
    endtask

    task automatic test_basic();
        res_t exp;
        sb.push_back('{bcd: 16'h0159, ndig: 3'd3, ec: 1'b0, eo: 1'b0});
        stim = '{4'h4, 4'h8, 4'hC};
        send_stim(1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL basic_latency: out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
        else n_pass++;
        exp = sb.pop_front();
        n_checks++;
        if (sample() !== exp) $display("FAIL basic_word: got %h expected %h", sample(), exp);
        else n_pass++;
    endtask

    // Stall in HOLD with in_valid asserted; nothing may change or be accepted.
    task automatic test_hold_stall();
        int bad = 0;
        in_valid = 1'b1; in_e3 = 4'h5; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== 16'h0159 || out_ndig !== 3'd3) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL hold_stable: %0d unstable cycles expected 0", bad);
        else n_pass++;
        in_valid = 1'b0; in_last = 1'b0;
        release_out();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'h0 || out_ndig !== 3'd0)
            $display("FAIL hold_release: valid=%b ready=%b bcd=%h ndig=%0d expected 0 1 0 0",
                     out_valid, in_ready, out_bcd, out_ndig);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_ndig !== 3'd0)
            $display("FAIL hold_no_accept: valid=%b ndig=%0d expected 0 0", out_valid, out_ndig);
        else n_pass++;
    endtask

    task automatic test_illegal();
        res_t exp;
        sb.push_back('{bcd: 16'h0004, ndig: 3'd3, ec: 1'b1, eo: 1'b0});
        sb.push_back('{bcd: 16'h0000, ndig: 3'd1, ec: 1'b1, eo: 1'b0});
        stim = '{4'h3, 4'hF, 4'h7};
        send_stim(1'b1);
        exp = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || sample() !== exp)
            $display("FAIL illegal_mix: valid=%b got %h expected %h", out_valid, sample(), exp);
        else n_pass++;
        release_out();
        stim = '{4'h2};
        send_stim(1'b1);
        exp = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || sample() !== exp)
            $display("FAIL illegal_single: valid=%b got %h expected %h", out_valid, sample(), exp);
        else n_pass++;
        release_out();
    endtask

    task automatic test_overflow();
        res_t exp;
        sb.push_back('{bcd: 16'h3456, ndig: 3'd4, ec: 1'b0, eo: 1'b1});
        stim = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        send_stim(1'b1);
        exp = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || sample() !== exp)
            $display("FAIL overflow: valid=%b got %h expected %h", out_valid, sample(), exp);
        else n_pass++;
        release_out();
    endtask

    task automatic test_reset_mid();
        res_t exp;
        sb.push_back('{bcd: 16'h0008, ndig: 3'd1, ec: 1'b0, eo: 1'b0});
        stim = '{4'h5, 4'h6};
        send_stim(1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (sample() !== res_t'(0) || in_ready !== 1'b1)
            $display("FAIL reset_mid_clear: got %h ready=%b expected 0 1", sample(), in_ready);
        else n_pass++;
        stim = '{4'hB};
        send_stim(1'b1);
        exp = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || sample() !== exp)
            $display("FAIL reset_mid_word: valid=%b got %h expected %h", out_valid, sample(), exp);
        else n_pass++;
        release_out();
    endtask

    task automatic test_all_codes();
        res_t exp;
        for (int c = 0; c < 16; c++) begin
            if (c >= 3 && c <= 12) sb.push_back('{bcd: 16'(c - 3), ndig: 3'd1, ec: 1'b0, eo: 1'b0});
            else                   sb.push_back('{bcd: 16'h0,      ndig: 3'd1, ec: 1'b1, eo: 1'b0});
            stim = '{4'(c)};
            send_stim(1'b1);
            exp = sb.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || sample() !== exp)
                $display("FAIL code_%0d: valid=%b got %h expected %h", c, out_valid, sample(), exp);
            else n_pass++;
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_illegal();
        test_overflow();
        test_reset_mid();
        test_all_codes();
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
